// File: rtl/cv32e41s_data_obi_responder.sv
// OBI data-side responder with Xsecure interface integrity.
// It checks the A-channel parity and checksum, and drives a single-cycle
// SRAM-style memory port. It returns in-order R-channel responses, with
// rvalidpar, gntpar and rchk generated.
// Read data is taken from memory one cycle after the command. A one-entry
// stage register holds per-transaction status until the data arrives. The
// stage register then pushes the completed response into a small circular
// FIFO that feeds the R channel.

module cv32e41s_data_obi_responder #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MEM_ADDR_WIDTH  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      obi_req_i,
    input  logic                      obi_reqpar_i,
    input  logic [31:0]               obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [3:0]                obi_be_i,
    input  logic [31:0]               obi_wdata_i,
    input  logic [2:0]                obi_prot_i,
    input  logic [1:0]                obi_memtype_i,
    input  logic                      obi_dbg_i,
    input  logic [12:0]               obi_achk_i,

    output logic                      obi_gnt_o,
    output logic                      obi_gntpar_o,
    output logic                      obi_rvalid_o,
    output logic                      obi_rvalidpar_o,
    output logic [31:0]               obi_rdata_o,
    output logic                      obi_err_o,
    output logic                      obi_exokay_o,
    output logic [4:0]                obi_rchk_o,

    input  logic                      gnt_stall_i,
    input  logic                      rvalid_stall_i,

    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i,

    output logic                      integrity_err_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int HI_LSB = MEM_ADDR_WIDTH + 2;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    // Expected A-channel checksum, recomputed from the received payload.
    function automatic logic [12:0] achk_calc(
        input logic [31:0] addr,
        input logic        we,
        input logic [3:0]  be,
        input logic [31:0] wdata,
        input logic [2:0]  prot,
        input logic [1:0]  memtype,
        input logic        dbg
    );
        logic [12:0] chk;
        chk[12] = ^wdata[31:24];
        chk[11] = ^wdata[23:16];
        chk[10] = ^wdata[15:8];
        chk[9]  = ^wdata[7:0];
        chk[8]  = ~^dbg;
        chk[7]  = 1'b0;
        chk[6]  = 1'b0;
        chk[5]  = ~^{be, we};
        chk[4]  = ~^{prot, memtype};
        chk[3]  = ^addr[31:24];
        chk[2]  = ^addr[23:16];
        chk[1]  = ^addr[15:8];
        chk[0]  = ^addr[7:0];
        return chk;
    endfunction

    // R-channel checksum over the values actually driven on the bus.
    function automatic logic [4:0] rchk_calc(
        input logic [31:0] rdata,
        input logic        err,
        input logic        exokay
    );
        logic [4:0] chk;
        chk[4] = ^{err, exokay};
        chk[3] = ^rdata[31:24];
        chk[2] = ^rdata[23:16];
        chk[1] = ^rdata[15:8];
        chk[0] = ^rdata[7:0];
        return chk;
    endfunction

    // Circular pointer advance with wrap at the last FIFO slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // Request-side decode
    logic [12:0]       achk_exp_s;
    logic              reqpar_err_s;
    logic              achk_err_s;
    logic              addr_oor_s;
    logic              gnt_s;
    logic              accept_s;
    logic              bad_s;

    // Transaction tracking
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;

    // Stage register P: status of the transaction whose read data arrives next cycle
    logic              p_valid_q, p_valid_d;
    logic              p_err_q,   p_err_d;
    logic              p_we_q,    p_we_d;

    // Response FIFO
    logic [31:0]       fifo_rdata_q [MAX_OUTSTANDING];
    logic              fifo_err_q   [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       push_rdata_s;

    // Integrity checks, grant and accept decision
    always_comb begin
        achk_exp_s   = achk_calc(obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
                                 obi_prot_i, obi_memtype_i, obi_dbg_i);
        reqpar_err_s = (obi_req_i == obi_reqpar_i);
        achk_err_s   = obi_req_i && (obi_achk_i != achk_exp_s);
        addr_oor_s   = |(obi_addr_i >> HI_LSB);
        gnt_s        = !gnt_stall_i && (outstanding_q < MAX_CNT);
        accept_s     = obi_req_i && gnt_s;
        bad_s        = achk_err_s || reqpar_err_s || addr_oor_s;
    end

    // Stage-register push and FIFO pop qualification
    always_comb begin
        push_s = p_valid_q;
        if (p_we_q || p_err_q) begin
            push_rdata_s = 32'h0000_0000;
        end else begin
            push_rdata_s = mem_rdata_i;
        end
        pop_s = (fifo_cnt_q != CNT_ZERO) && !rvalid_stall_i;
    end

    // Next-state for the outstanding counter, stage register, and FIFO bookkeeping
    always_comb begin
        if (accept_s && !pop_s) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!accept_s && pop_s) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end else begin
            outstanding_d = outstanding_q;
        end

        p_valid_d = accept_s;
        p_err_d   = accept_s && bad_s;
        p_we_d    = accept_s && obi_we_i;

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && !pop_s) begin
            fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            fifo_cnt_d = fifo_cnt_q - CNT_ONE;
        end else begin
            fifo_cnt_d = fifo_cnt_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= CNT_ZERO;
            p_valid_q     <= 1'b0;
            p_err_q       <= 1'b0;
            p_we_q        <= 1'b0;
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            fifo_cnt_q    <= CNT_ZERO;
        end else begin
            outstanding_q <= outstanding_d;
            p_valid_q     <= p_valid_d;
            p_err_q       <= p_err_d;
            p_we_q        <= p_we_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Response FIFO storage, written at the write pointer on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_rdata_q[i] <= 32'h0000_0000;
                fifo_err_q[i]   <= 1'b0;
            end
        end else if (push_s) begin
            fifo_rdata_q[wr_ptr_q] <= push_rdata_s;
            fifo_err_q[wr_ptr_q]   <= p_err_q;
        end
    end

    // Bus and memory output drive; the response payload is zero whenever rvalid is low
    always_comb begin
        obi_gnt_o       = gnt_s;
        obi_gntpar_o    = !gnt_s;
        obi_rvalid_o    = pop_s;
        obi_rvalidpar_o = !pop_s;
        obi_exokay_o    = 1'b0;
        if (pop_s) begin
            obi_rdata_o = fifo_rdata_q[rd_ptr_q];
            obi_err_o   = fifo_err_q[rd_ptr_q];
        end else begin
            obi_rdata_o = 32'h0000_0000;
            obi_err_o   = 1'b0;
        end
        obi_rchk_o      = rchk_calc(obi_rdata_o, obi_err_o, obi_exokay_o);

        mem_req_o       = accept_s && !bad_s;
        mem_we_o        = obi_we_i;
        mem_be_o        = obi_be_i;
        mem_addr_o      = obi_addr_i[MEM_ADDR_WIDTH+1:2];
        mem_wdata_o     = obi_wdata_i;

        integrity_err_o = reqpar_err_s || achk_err_s;
    end

endmodule

// File: tb/tb_cv32e41s_data_obi_responder.sv
// Self-checking bench for cv32e41s_data_obi_responder.
// A transaction-level model predicts every output on every cycle. The model
// holds the expected memory image and a timed queue of expected responses.
// Directed scenarios pin key values with literal expectations. A long random
// phase follows them.

module tb_cv32e41s_data_obi_responder;

    localparam int MAXO = 2;
    localparam int AW   = 14;
    localparam int WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        obi_req_i, obi_reqpar_i, obi_we_i, obi_dbg_i;
    logic [31:0] obi_addr_i, obi_wdata_i;
    logic [3:0]  obi_be_i;
    logic [2:0]  obi_prot_i;
    logic [1:0]  obi_memtype_i;
    logic [12:0] obi_achk_i;
    logic        obi_gnt_o, obi_gntpar_o, obi_rvalid_o, obi_rvalidpar_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o, obi_exokay_o;
    logic [4:0]  obi_rchk_o;
    logic        gnt_stall_i, rvalid_stall_i;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        integrity_err_o;

    always #5 clk = ~clk;

    cv32e41s_data_obi_responder #(.MAX_OUTSTANDING(MAXO), .MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .obi_req_i(obi_req_i), .obi_reqpar_i(obi_reqpar_i), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_prot_i(obi_prot_i), .obi_memtype_i(obi_memtype_i), .obi_dbg_i(obi_dbg_i),
        .obi_achk_i(obi_achk_i),
        .obi_gnt_o(obi_gnt_o), .obi_gntpar_o(obi_gntpar_o),
        .obi_rvalid_o(obi_rvalid_o), .obi_rvalidpar_o(obi_rvalidpar_o),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o), .obi_exokay_o(obi_exokay_o),
        .obi_rchk_o(obi_rchk_o),
        .gnt_stall_i(gnt_stall_i), .rvalid_stall_i(rvalid_stall_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .integrity_err_o(integrity_err_o)
    );

    function automatic logic [31:0] init_pat(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Environment SRAM: single-cycle, read data one cycle after the command.
    logic [31:0] sram [WORDS];
    logic        sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= init_pat(i);
            sram_init <= 1'b1;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // Reference model state
    typedef struct { logic [31:0] rdata; logic err; int ready; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] mdl_mem [WORDS];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    // Values observed in the most recent cycle, for the directed literal checks
    logic        obs_rv, obs_rvp, obs_err, obs_gnt, obs_gntp, obs_mem_req, obs_int;
    logic [31:0] obs_rdata;
    logic [4:0]  obs_rchk;
    logic [AW-1:0] obs_mem_addr;

    function automatic logic [12:0] achk_fn(input logic [31:0] a, input logic we,
        input logic [3:0] be, input logic [31:0] wd, input logic [2:0] pr,
        input logic [1:0] mt, input logic dbg);
        logic [12:0] c;
        c = {^wd[31:24], ^wd[23:16], ^wd[15:8], ^wd[7:0], ~dbg, 1'b0, 1'b0,
             ~^{be, we}, ~^{pr, mt}, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
        return c;
    endfunction

    function automatic logic [4:0] rchk_fn(input logic [31:0] d, input logic err);
        return {err, ^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'h0, act}, {31'h0, exp});
    endtask

    // Per-cycle comparison against the model, then advance the model by one clock.
    task automatic check_cycle();
        logic rpe, ace, gnt_e, acc, oor, bad, rv_e, err_e;
        logic [31:0] rd_e;
        int w;
        rsp_t r;
        obs_rv = obi_rvalid_o; obs_rvp = obi_rvalidpar_o; obs_err = obi_err_o;
        obs_rdata = obi_rdata_o; obs_rchk = obi_rchk_o; obs_gnt = obi_gnt_o;
        obs_gntp = obi_gntpar_o; obs_mem_req = mem_req_o; obs_int = integrity_err_o;
        obs_mem_addr = mem_addr_o;

        rpe = (obi_req_i == obi_reqpar_i);
        ace = obi_req_i && (obi_achk_i != achk_fn(obi_addr_i, obi_we_i, obi_be_i,
                  obi_wdata_i, obi_prot_i, obi_memtype_i, obi_dbg_i));
        chk1("integrity_err", integrity_err_o, rpe || ace);
        chk1("exokay", obi_exokay_o, 1'b0);

        if (!rst_n) begin
            exp_q.delete();
            chk1("rst_rvalid", obi_rvalid_o, 1'b0);
            chk1("rst_rvalidpar", obi_rvalidpar_o, 1'b1);
            chk32("rst_rdata", obi_rdata_o, 32'h0);
            chk1("rst_mem_req", mem_req_o, 1'b0);
            chk1("rst_gnt", obi_gnt_o, !gnt_stall_i);
            chk1("rst_gntpar", obi_gntpar_o, gnt_stall_i);
        end else begin
            gnt_e = !gnt_stall_i && (exp_q.size() < MAXO);
            chk1("gnt", obi_gnt_o, gnt_e);
            chk1("gntpar", obi_gntpar_o, !gnt_e);
            acc = obi_req_i && gnt_e;
            oor = ({32'h0, obi_addr_i} >= (64'd4 << AW));
            bad = ace || rpe || oor;
            rv_e = (exp_q.size() != 0) && (exp_q[0].ready <= cyc) && !rvalid_stall_i;
            rd_e = rv_e ? exp_q[0].rdata : 32'h0;
            err_e = rv_e ? exp_q[0].err : 1'b0;
            chk1("rvalid", obi_rvalid_o, rv_e);
            chk1("rvalidpar", obi_rvalidpar_o, !rv_e);
            chk32("rdata", obi_rdata_o, rd_e);
            chk1("err", obi_err_o, err_e);
            chk32("rchk", {27'h0, obi_rchk_o}, {27'h0, rchk_fn(rd_e, err_e)});
            chk1("mem_req", mem_req_o, acc && !bad);
            if (acc && !bad) begin
                chk32("mem_addr", {18'h0, mem_addr_o}, {18'h0, obi_addr_i[AW+1:2]});
                chk1("mem_we", mem_we_o, obi_we_i);
                chk32("mem_be", {28'h0, mem_be_o}, {28'h0, obi_be_i});
                chk32("mem_wdata", mem_wdata_o, obi_wdata_i);
            end
            if (rv_e) void'(exp_q.pop_front());
            if (acc) begin
                w = int'(obi_addr_i[AW+1:2]);
                r.err = bad;
                r.ready = cyc + 2;
                r.rdata = (obi_we_i || bad) ? 32'h0 : mdl_mem[w];
                if (obi_we_i && !bad)
                    for (int b = 0; b < 4; b++)
                        if (obi_be_i[b]) mdl_mem[w][8*b +: 8] = obi_wdata_i[8*b +: 8];
                exp_q.push_back(r);
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input int flip, input logic par_bad);
        logic [12:0] a;
        obi_req_i     = req;
        obi_reqpar_i  = par_bad ? req : ~req;
        obi_we_i      = we;
        obi_addr_i    = addr;
        obi_be_i      = be;
        obi_wdata_i   = wdata;
        obi_prot_i    = 3'($urandom_range(0, 7));
        obi_memtype_i = 2'($urandom_range(0, 3));
        obi_dbg_i     = 1'($urandom_range(0, 1));
        a = achk_fn(addr, we, be, wdata, obi_prot_i, obi_memtype_i, obi_dbg_i);
        if (flip >= 0) a[flip] = ~a[flip];
        obi_achk_i = a;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, -1, 1'b0);
    endtask

    initial begin
        int sel;
        for (int i = 0; i < WORDS; i++) mdl_mem[i] = init_pat(i);
        rst_n = 1'b0; gnt_stall_i = 1'b0; rvalid_stall_i = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 3; i++) step();
        chk1("lit_rst_rvalidpar", obs_rvp, 1'b1);
        chk1("lit_rst_gnt", obs_gnt, 1'b1);
        rst_n = 1'b1;
        step();

        // Read after write
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hA5A5_0F0F, -1, 1'b0); step();
        chk1("lit_raw_wr_mem_req", obs_mem_req, 1'b1);
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, -1, 1'b0); step();
        idle(); step();
        chk1("lit_raw_wr_rvalid", obs_rv, 1'b1);
        chk1("lit_raw_wr_err", obs_err, 1'b0);
        chk32("lit_raw_wr_rdata", obs_rdata, 32'h0);
        idle(); step();
        chk1("lit_raw_rd_rvalid_lat2", obs_rv, 1'b1);
        chk32("lit_raw_rd_rdata", obs_rdata, 32'hA5A5_0F0F);
        chk32("lit_raw_rd_rchk", {27'h0, obs_rchk}, 32'h0);
        chk1("lit_raw_rd_rvalidpar", obs_rvp, 1'b0);

        // Backpressure
        rvalid_stall_i = 1'b1;
        drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, -1, 1'b0); step();
        drive(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, -1, 1'b0); step();
        chk1("lit_bp_gnt2", obs_gnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h108, 4'hF, 32'h0, -1, 1'b0); step();
            chk1("lit_bp_gnt_low", obs_gnt, 1'b0);
            chk1("lit_bp_gntpar_high", obs_gntp, 1'b1);
        end
        rvalid_stall_i = 1'b0;
        drive(1'b1, 1'b0, 32'h108, 4'hF, 32'h0, -1, 1'b0); step();
        chk1("lit_bp_rsp1_valid", obs_rv, 1'b1);
        chk32("lit_bp_rsp1_data", obs_rdata, init_pat(32'h40));
        drive(1'b1, 1'b0, 32'h108, 4'hF, 32'h0, -1, 1'b0); step();
        chk1("lit_bp_rsp2_valid", obs_rv, 1'b1);
        chk32("lit_bp_rsp2_data", obs_rdata, init_pat(32'h41));
        chk1("lit_bp_third_gnt", obs_gnt, 1'b1);
        idle(); step();
        idle(); step();
        chk32("lit_bp_rsp3_data", obs_rdata, init_pat(32'h42));

        // Bad achk on a write
        drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h1234_5678, 5, 1'b0); step();
        chk1("lit_achk_int", obs_int, 1'b1);
        chk1("lit_achk_mem_req", obs_mem_req, 1'b0);
        idle(); step();
        chk1("lit_achk_int_pulse_end", obs_int, 1'b0);
        idle(); step();
        chk1("lit_achk_rvalid", obs_rv, 1'b1);
        chk1("lit_achk_err", obs_err, 1'b1);
        chk1("lit_achk_rchk4", obs_rchk[4], 1'b1);
        drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, -1, 1'b0); step();
        idle(); step();
        idle(); step();
        chk32("lit_achk_readback", obs_rdata, init_pat(8));

        // reqpar error while idle
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, -1, 1'b1); step();
        chk1("lit_reqpar_idle_int", obs_int, 1'b1);
        chk1("lit_reqpar_idle_mem_req", obs_mem_req, 1'b0);
        idle(); step();
        idle(); step();
        chk1("lit_reqpar_idle_no_rsp", obs_rv, 1'b0);

        // Out-of-range read, plus last in-range word
        drive(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, -1, 1'b0); step();
        chk1("lit_oor_mem_req", obs_mem_req, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0, -1, 1'b0); step();
        chk32("lit_top_mem_addr", {18'h0, obs_mem_addr}, 32'h3FFF);
        idle(); step();
        chk1("lit_oor_err", obs_err, 1'b1);
        chk32("lit_oor_rdata", obs_rdata, 32'h0);
        idle(); step();
        chk1("lit_top_err", obs_err, 1'b0);
        chk32("lit_top_rdata", obs_rdata, init_pat(WORDS - 1));

        // Reset with two transactions outstanding
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, -1, 1'b0); step();
        drive(1'b1, 1'b0, 32'h14, 4'hF, 32'h0, -1, 1'b0); step();
        rst_n = 1'b0; idle(); step();
        chk1("lit_rstmid_rvalid", obs_rv, 1'b0);
        step();
        rst_n = 1'b1; step();
        chk1("lit_rstmid_gnt", obs_gnt, 1'b1);
        idle(); step();
        chk1("lit_rstmid_no_rsp", obs_rv, 1'b0);
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, -1, 1'b0); step();
        idle(); step();
        idle(); step();
        chk1("lit_rstmid_new_rvalid", obs_rv, 1'b1);
        chk32("lit_rstmid_new_rdata", obs_rdata, 32'hA5A5_0F0F);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 19));
            gnt_stall_i    = ($urandom_range(0, 7) == 0);
            rvalid_stall_i = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 1)),
                  (sel == 0) ? $urandom() :
                  (sel == 1) ? (32'h0000_FFFC | 32'($urandom_range(0, 3))) :
                               32'($urandom_range(0, 63)),
                  4'($urandom_range(0, 15)),
                  $urandom(),
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 12)) : -1,
                  1'($urandom_range(0, 31) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
